// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: next-PC select encodings, bubble word and
// the IF/ID pipeline payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_JALR   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcSrc_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
  } ifIdPayload_t;

  localparam int unsigned IFID_W = $bits(ifIdPayload_t);

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage and the execute resolver, hazard unit,
// instruction memory and decode.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic [1:0]      PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] ALUResultE;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            MisalignF;

  modport master (
    output PCSrcE, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, MisalignF
  );

  modport slave (
    input  PCSrcE, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, MisalignF
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with clear (priority) and enable; reused for
// every inter-stage register of the core.
module if_id_reg #(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    RST_VAL = '0,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I core: PC register, next-PC select, sticky
// misaligned-redirect flag and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  import riscv_pkg::*;

  localparam ifIdPayload_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0};

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] pcNext;
  logic            redirect;
  logic            misalignHit;
  logic            misalignF;
  pcSrc_t          pcSrc;
  ifIdPayload_t    ifIdD;
  ifIdPayload_t    ifIdQ;

  assign pcPlus4F = pcF + XLEN'(4);

  // Next-PC select; the reserved encoding behaves like sequential fetch
  always_comb begin
    pcSrc       = pcSrc_t'(bus.PCSrcE);
    pcNext      = pcPlus4F;
    redirect    = 1'b0;
    misalignHit = 1'b0;
    case (pcSrc)
      PCSRC_TARGET: begin
        pcNext      = bus.PCTargetE;
        redirect    = 1'b1;
        misalignHit = |bus.PCTargetE[1:0];
      end
      PCSRC_JALR: begin
        pcNext      = bus.ALUResultE & ~XLEN'(1);
        redirect    = 1'b1;
        misalignHit = bus.ALUResultE[1];
      end
      default: ;
    endcase
  end

  // A taken redirect overrides a fetch stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pcF <= RESET_PC;
    else if (redirect || !bus.StallF) pcF <= pcNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          misalignF <= 1'b0;
    else if (redirect && misalignHit) misalignF <= 1'b1;
  end

  assign ifIdD = '{instr: bus.InstrF, pc: pcF, pcPlus4: pcPlus4F};

  if_id_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_BUBBLE),
    .CLR_VAL (IFID_BUBBLE)
  ) u_if_id_reg (
    .clk (clk),
    .rst (rst),
    .en  (!bus.StallD),
    .clr (bus.FlushD),
    .d   (ifIdD),
    .q   (ifIdQ)
  );

  assign bus.PCF       = pcF;
  assign bus.InstrD    = ifIdQ.instr;
  assign bus.PCD       = ifIdQ.pc;
  assign bus.PCPlus4D  = ifIdQ.pcPlus4;
  assign bus.MisalignF = misalignF;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch/IF-ID rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  logic [31:0] mPC, mInstrD, mPCD, mP4D;
  logic        mMis;

  fetch_stage_if intf ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h1C) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  always_comb intf.InstrF = imem(intf.PCF);

  task automatic model_reset();
    mPC = 32'h0; mInstrD = NOP; mPCD = 32'h0; mP4D = 32'h0; mMis = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample 1ns later
  task automatic tick(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                      input logic sf, input logic sd, input logic fd);
    logic [31:0] t;
    logic        redir;
    intf.PCSrcE = src; intf.PCTargetE = tgt; intf.ALUResultE = alu;
    intf.StallF = sf;  intf.StallD = sd;     intf.FlushD = fd;
    @(posedge clk);
    redir = (src == 2'd1) || (src == 2'd2);
    t = (src == 2'd1) ? tgt : alu - (alu % 2);
    if (redir && (t % 4 != 0)) mMis = 1'b1;
    if (fd) begin
      mInstrD = NOP; mPCD = 32'h0; mP4D = 32'h0;
    end else if (!sd) begin
      mInstrD = imem(mPC); mPCD = mPC; mP4D = mPC + 32'd4;
    end
    mPC = redir ? t : (sf ? mPC : mPC + 32'd4);
    #1;
  endtask

  task automatic plain();
    tick(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (16) plain();
    checks++; if (intf.PCF !== 32'h40) begin errors++; $display("FAIL rst_pre_pcf: got %h want %h", intf.PCF, 32'h40); end
    #2 rst = 1'b1;
    #1 model_reset();
    checks++; if (intf.PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf: got %h want 0", intf.PCF); end
    checks++; if (intf.InstrD !== NOP) begin errors++; $display("FAIL rst_instrd: got %h want %h", intf.InstrD, NOP); end
    checks++; if (intf.PCD !== 32'h0 || intf.PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pcd: got %h/%h want 0/0", intf.PCD, intf.PCPlus4D); end
    checks++; if (intf.MisalignF !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", intf.MisalignF); end
    @(negedge clk) rst = 1'b0;
    plain();
    checks++; if (intf.PCF !== 32'h4 || intf.PCD !== 32'h0) begin errors++; $display("FAIL rst_first: pcf %h pcd %h want 4 0", intf.PCF, intf.PCD); end
    plain();
    checks++; if (intf.PCF !== 32'h8 || intf.PCD !== 32'h4 || intf.InstrD !== imem(32'h4)) begin
      errors++; $display("FAIL rst_second: pcf %h pcd %h instr %h", intf.PCF, intf.PCD, intf.InstrD); end
  endtask

  task automatic test_branch();
    repeat (2) plain();
    checks++; if (intf.PCF !== 32'h10) begin errors++; $display("FAIL br_pre: got %h want 10", intf.PCF); end
    tick(2'd1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (intf.PCF !== 32'h100) begin errors++; $display("FAIL br_pcf: got %h want 100", intf.PCF); end
    checks++; if (intf.InstrD !== NOP || intf.PCD !== 32'h0) begin errors++; $display("FAIL br_flush: instr %h pcd %h", intf.InstrD, intf.PCD); end
    plain();
    checks++; if (intf.PCD !== 32'h100 || intf.PCPlus4D !== 32'h104) begin errors++; $display("FAIL br_next: pcd %h p4 %h want 100 104", intf.PCD, intf.PCPlus4D); end
  endtask

  task automatic test_jalr();
    tick(2'd2, 32'h0, 32'h205, 1'b0, 1'b0, 1'b1);
    checks++; if (intf.PCF !== 32'h204 || intf.MisalignF !== 1'b0) begin errors++; $display("FAIL jalr_even: pcf %h mis %b want 204 0", intf.PCF, intf.MisalignF); end
    tick(2'd2, 32'h0, 32'h206, 1'b0, 1'b0, 1'b1);
    checks++; if (intf.PCF !== 32'h206 || intf.MisalignF !== 1'b1) begin errors++; $display("FAIL jalr_mis: pcf %h mis %b want 206 1", intf.PCF, intf.MisalignF); end
    repeat (3) plain();
    checks++; if (intf.PCF !== 32'h212 || intf.MisalignF !== 1'b1) begin errors++; $display("FAIL jalr_sticky: pcf %h mis %b want 212 1", intf.PCF, intf.MisalignF); end
  endtask

  task automatic test_stall();
    tick(2'd1, 32'h1C, 32'h0, 1'b0, 1'b0, 1'b1);
    plain();
    checks++; if (intf.PCF !== 32'h20 || intf.InstrD !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_pre: pcf %h instr %h", intf.PCF, intf.InstrD); end
    tick(2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (intf.PCF !== 32'h20) begin errors++; $display("FAIL st_pcf: got %h want 20", intf.PCF); end
    checks++; if (intf.InstrD !== 32'hDEAD_BEEF || intf.PCD !== 32'h1C || intf.PCPlus4D !== 32'h20) begin
      errors++; $display("FAIL st_hold: instr %h pcd %h p4 %h", intf.InstrD, intf.PCD, intf.PCPlus4D); end
    plain();
    checks++; if (intf.PCF !== 32'h24 || intf.PCD !== 32'h20) begin errors++; $display("FAIL st_resume: pcf %h pcd %h want 24 20", intf.PCF, intf.PCD); end
  endtask

  task automatic test_priority();
    tick(2'd1, 32'h80, 32'h0, 1'b1, 1'b1, 1'b1);
    checks++; if (intf.PCF !== 32'h80 || intf.InstrD !== NOP || intf.PCD !== 32'h0) begin
      errors++; $display("FAIL prio: pcf %h instr %h pcd %h want 80 %h 0", intf.PCF, intf.InstrD, intf.PCD, NOP); end
    tick(2'd3, 32'h300, 32'h400, 1'b0, 1'b0, 1'b0);
    checks++; if (intf.PCF !== 32'h84 || intf.PCD !== 32'h80) begin errors++; $display("FAIL rsvd: pcf %h pcd %h want 84 80", intf.PCF, intf.PCD); end
  endtask

  task automatic test_wrap();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    tick(2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b1);
    plain();
    checks++; if (intf.PCF !== 32'h0 || intf.PCPlus4D !== 32'h0 || intf.PCD !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap: pcf %h p4 %h pcd %h", intf.PCF, intf.PCPlus4D, intf.PCD); end
    checks++; if (intf.MisalignF !== 1'b0) begin errors++; $display("FAIL wrap_mis: got %b want 0", intf.MisalignF); end
  endtask

  task automatic test_random();
    logic [31:0] tgt, alu;
    logic [1:0]  src;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
      end
      src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) src = 2'd0;
      tgt = $urandom; alu = $urandom;
      if ($urandom_range(0, 15) != 0) begin tgt[1:0] = 2'b00; alu[1] = 1'b0; end
      tick(src, tgt, alu, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 5) == 0));
      checks++;
      if (intf.PCF !== mPC || intf.InstrD !== mInstrD || intf.PCD !== mPCD ||
          intf.PCPlus4D !== mP4D || intf.MisalignF !== mMis) begin
        errors++;
        $display("FAIL rand_%0d: got %h %h %h %h %b want %h %h %h %h %b", i,
                 intf.PCF, intf.InstrD, intf.PCD, intf.PCPlus4D, intf.MisalignF,
                 mPC, mInstrD, mPCD, mP4D, mMis);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    intf.PCSrcE = 2'd0; intf.PCTargetE = 32'h0; intf.ALUResultE = 32'h0;
    intf.StallF = 1'b0; intf.StallD = 1'b0;     intf.FlushD = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_priority();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
